// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared sizing for the single-port-RAM FIFO controller; defaults match the 16x8 sync RAM.
`timescale 1ns/1ps
package sp_ram_fifo_ctrl_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Push/pop stream bundle for the FIFO controller.
`timescale 1ns/1ps
interface sp_ram_fifo_ctrl_if
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);
  // Handshake: a word moves on a rising edge where valid && ready are both high;
  // valid never depends on ready, and data is stable whenever valid is high.
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/sp_ram_fifo_ptr.sv
// Write/read pointers and RAM occupancy counter for the single-port FIFO.
`timescale 1ns/1ps
module sp_ram_fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_wr_i,
  input  logic              inc_rd_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   ram_cnt_o,
  output logic              full_o
);
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (inc_wr_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (inc_rd_i) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({inc_wr_i, inc_rd_i})
      2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign ram_cnt_o = ram_cnt_q;
  assign full_o    = (ram_cnt_q == DEPTH_L);
endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller sharing one single-port sync RAM between push and pop; reads win the port
// and the RAM's one-cycle read latency is hidden behind a registered output word.
`timescale 1ns/1ps
module sp_ram_fifo_ctrl
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  sp_ram_fifo_ctrl_if.slave   bus,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic                rd_pend_o
);
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_go;
  logic              s_ready;
  logic              push;

  logic              rd_pend_q, rd_pend_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;

  sp_ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_wr_i  (push),
    .inc_rd_i  (rd_go),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .ram_cnt_o (ram_cnt),
    .full_o    (full)
  );

  // One read in flight at a time, issued only when the output slot will be free to take it.
  assign rd_go   = (ram_cnt != '0) && !rd_pend_q && (!m_valid_q || bus.m_ready);
  assign s_ready = rst_n && !rd_go && !full;
  assign push    = bus.s_valid && s_ready;

  assign ram_we   = push;
  assign ram_addr = rd_go ? rd_ptr : wr_ptr;
  assign ram_din  = bus.s_data;

  always_comb begin
    rd_pend_d = rd_go;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (rd_pend_q) begin
      m_data_d  = ram_dout;
      m_valid_d = 1'b1;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign count       = ram_cnt + {{ADDR_W{1'b0}}, m_valid_q};
  assign empty       = (count == '0);
  assign rd_pend_o   = rd_pend_q;
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl with a behavioural 16x8 sync RAM and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_sp_ram_fifo_ctrl;
  import sp_ram_fifo_ctrl_pkg::*;

  localparam int W  = FIFO_DATA_W;
  localparam int AW = FIFO_ADDR_W;
  localparam int D  = FIFO_DEPTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- DUT + RAM ----------------
  sp_ram_fifo_ctrl_if #(.DATA_W(W)) bus();

  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout;
  logic          rd_pend;

  sp_ram_fifo_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .rd_pend_o (rd_pend)
  );

  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int           checks  = 0;
  int           errors  = 0;
  bit           started = 0;
  int           wr_idx  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  // Words held = pushed minus popped; the one word travelling RAM->output is not counted.
  always @(negedge clk) begin
    if (started) begin
      int held;
      int ram_occ;
      logic [W-1:0] e;
      held    = exp_q.size();
      ram_occ = held - int'(rd_pend) - int'(bus.m_valid);
      chk("pend_excludes_valid", rd_pend && bus.m_valid, 0);
      chk("count", count, held - int'(rd_pend));
      chk("empty", empty, (held - int'(rd_pend)) == 0);
      chk("full", full, ram_occ == D);
      if (ram_occ >= D) chk("s_ready_when_full", bus.s_ready, 0);
      chk("ram_we", ram_we, bus.s_valid && bus.s_ready && rst_n);
      if (rst_n) begin
        if (bus.m_valid && bus.m_ready) begin
          chk("pop_model_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pop_data", bus.m_data, e);
          end
        end
        if (bus.s_valid && bus.s_ready) begin
          chk("wr_addr", ram_addr, wr_idx % D);
          exp_q.push_back(bus.s_data);
          wr_idx++;
        end
      end else begin
        exp_q.delete();
        wr_idx = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit sv);
    rst_n       = 1'b0;
    bus.s_valid = sv;
    bus.s_data  = W'($urandom);
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("reset_no_we", ram_we, 0);
    chk("reset_no_ready", bus.s_ready, 0);
    step();
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
  endtask

  task automatic single_word(logic [W-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("sw_we_n", ram_we, 1);
    chk("sw_addr_n", ram_addr, 0);
    step();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("sw_we_n1", ram_we, 0);
    chk("sw_addr_n1", ram_addr, 0);
    step();
    step();
    @(negedge clk);
    chk("sw_valid_n3", bus.m_valid, 1);
    chk("sw_data_n3", bus.m_data, d);
    chk("sw_count_n3", count, 1);
    step();
  endtask

  task automatic push_n(int n, bit mr, int budget);
    int acc = 0;
    for (int i = 0; i < budget && acc < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'($urandom);
      bus.m_ready = mr;
      @(negedge clk);
      if (bus.s_ready) acc++;
      step();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    chk("push_n_accepted", acc, n);
  endtask

  task automatic drain(int budget, bit check_gap);
    int prev = -1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count == 0 && !rd_pend) begin
        step();
        break;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (check_gap && prev >= 0) chk("pop_gap", cyc_n - prev, 2);
        prev = cyc_n;
      end
      step();
    end
    bus.m_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nxt;
    int acc;
    int pops;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;

    // reset state, then a one-cycle reset with a push offered
    @(negedge clk);
    chk("idle_count", count, 0);
    chk("idle_empty", empty, 1);
    chk("idle_full", full, 0);
    chk("idle_valid", bus.m_valid, 0);
    chk("idle_we", ram_we, 0);
    step();
    do_reset(1'b1);
    @(negedge clk);
    chk("post_reset_count", count, 0);
    step();

    // single word latency
    single_word(8'hA5);
    drain(50, 1'b0);

    // fill to capacity with an incrementing pattern
    do_reset(1'b0);
    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'(nxt);
      @(negedge clk);
      if (bus.s_ready) nxt++;
      step();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", nxt, D + 1);
    chk("fill_count", count, D + 1);
    chk("fill_full", full, 1);
    chk("fill_s_ready", bus.s_ready, 0);
    chk("fill_valid", bus.m_valid, 1);
    chk("fill_head", bus.m_data, 0);
    step();
    drain(100, 1'b1);

    // offset pointers, then wrap them while refilling and draining
    do_reset(1'b0);
    push_n(10, 1'b0, 40);
    drain(60, 1'b0);
    push_n(16, 1'b0, 60);
    repeat (3) step();
    drain(100, 1'b1);

    // push and pop demand together with three words held
    do_reset(1'b0);
    push_n(3, 1'b0, 20);
    repeat (4) step();
    acc  = 0;
    pops = 0;
    for (int i = 0; i < 60; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'($urandom);
      bus.m_ready = 1'b1;
      @(negedge clk);
      if (bus.s_ready) acc++;
      if (bus.m_valid) pops++;
      step();
    end
    chk("simul_push_rate", acc >= 25, 1);
    chk("simul_pop_rate", pops >= 25, 1);
    drain(100, 1'b0);

    // randomized traffic with varying push/pop bias
    do_reset(1'b0);
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 200; i++) begin
        bus.s_valid = ($urandom_range(0, 3) < 3 - ph);
        bus.s_data  = W'($urandom);
        bus.m_ready = ($urandom_range(0, 3) <= ph);
        step();
      end
    end
    drain(100, 1'b0);

    // reset while a read is in flight with five words counted
    do_reset(1'b0);
    push_n(7, 1'b0, 30);
    repeat (3) step();
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("mid_pre_count", count, 7);
    step();
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    chk("mid_pend", rd_pend, 1);
    chk("mid_count", count, 5);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_valid", bus.m_valid, 0);
    chk("mid_after_count", count, 0);
    step();
    single_word(8'h3C);
    drain(50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation did not finish actual=timeout expected=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_ram_fifo_ctrl.md
Name: sp_ram_fifo_ctrl

Overview:
FIFO controller that drives the team's single-port 16x8 synchronous RAM (one write or one read per clock, registered read data) as a first-in-first-out queue. It sits directly upstream of the RAM, owns its we/addr/din pins and consumes its dout. Upstream producers see a valid/ready push port and downstream consumers see a valid/ready pop port. The block arbitrates the single RAM port between push and pop and hides the RAM's one-cycle read latency behind an output holding register.

Parameters:
DATA_W, 8, data word width; must equal the RAM data width
ADDR_W, 4, RAM address width
DEPTH, 2**ADDR_W, RAM words (derived, not overridable)

Ports:
clk  input  1  rising-edge clock shared with the RAM
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
s_valid  input  1  push request
s_ready  output  1  push accepted this cycle when s_valid is also high
s_data  input  DATA_W  push data
m_valid  output  1  m_data holds the oldest word
m_ready  input  1  consumer takes m_data when m_valid is also high
m_data  output  DATA_W  oldest word, registered
count  output  ADDR_W+1  words held: RAM occupancy plus 1 if m_valid (0..DEPTH+1)
full  output  1  RAM occupancy == DEPTH
empty  output  1  count == 0
ram_we  output  1  to RAM we
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM din
ram_dout  input  DATA_W  from RAM dout

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_W, wrap DEPTH-1 -> 0 naturally), ram_cnt (ADDR_W+1, 0..DEPTH), rd_pend (1), m_valid, m_data.
- Reset (rst_n low at an edge): wr_ptr=rd_ptr=0, ram_cnt=0, rd_pend=0, m_valid=0, m_data=0. Hence count=0, empty=1, full=0. While rst_n is low, s_ready=0 and ram_we=0. RAM contents are not cleared. A reset mid-operation discards all queued and in-flight words, and the cycle after reset behaves as an empty FIFO.
- Read issue (combinational): rd_go = (ram_cnt != 0) && !rd_pend && (!m_valid || m_ready). Reads have priority over writes.
- Push: s_ready = rst_n && !rd_go && (ram_cnt < DEPTH). A push happens when s_valid && s_ready.
- RAM drive (combinational): ram_we = push; ram_addr = rd_go ? rd_ptr : wr_ptr; ram_din = s_data. When neither operation occurs, ram_we=0 and ram_addr=wr_ptr. The RAM then performs an idle read, which the block ignores.
- On push: memory[wr_ptr] is written, wr_ptr+1, ram_cnt+1.
- On rd_go: rd_ptr+1, ram_cnt-1, and rd_pend=1 in the next cycle. Push and rd_go are mutually exclusive, so ram_cnt changes by at most 1 per cycle.
- Pending cycle (rd_pend=1): ram_dout carries the word read last cycle. At this edge m_data<=ram_dout, m_valid<=1, rd_pend<=0. The RAM's dout holds value under we=1, so a push in the pend cycle is legal.
- Pop: when m_valid && m_ready and no capture at the same edge, m_valid<=0 and m_data holds.
- Invariant: rd_pend=1 implies m_valid=0. The bench asserts this.
- Latency into an empty FIFO: push at cycle N, rd_go at N+1, capture at the end of N+2, m_valid=1 at N+3.
- Throughput: at most 1 pop per 2 cycles, because rd_pend blocks back-to-back reads. Writes fill the remaining cycles.
- Capacity is DEPTH+1 (17). full refers to RAM occupancy only.
- Writing while full is impossible because s_ready=0. Popping while empty is impossible because m_valid=0. No error flags.
- count and empty are combinational from registered state.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults matching the RAM, and DEPTH.
- No typedefs are needed.
- One natural sub-module: sp_ram_fifo_ptr, holding the pointer/occupancy counter (wr_ptr, rd_ptr, ram_cnt, full) with inc_wr/inc_rd strobes.
- The top level holds the arbitration, rd_pend and the output register, and instantiates sync_ram externally or in a wrapper.

Test Plan:
- Reset then idle: count=0, empty=1, full=0, m_valid=0, ram_we=0. Assert rst_n low for 1 cycle with s_valid=1: no ram_we and no count change.
- Single word: push 0xA5 at cycle N with m_ready=0 -> ram_we=1, ram_addr=0 at N; ram_addr=0, ram_we=0 at N+1; m_valid=1, m_data=0xA5, count=1 at N+3.
- Fill: m_ready=0, s_valid=1 continuously with data 0x00..0x20 -> exactly 17 accepted (0x00..0x10); full=1, count=17, s_ready=0; m_data=0x00.
- Drain with wrap: after 10 pushes/pops to offset the pointers, push 16 more, then m_ready=1 -> all words emerge in order, m_valid pulses every 2nd cycle, and wr_ptr/rd_ptr wrap 15->0 without loss.
- Simultaneous push and pop demand: s_valid=1 and m_ready=1 with FIFO holding 3 -> reads win on rd_go cycles and pushes fill the alternate cycles. Data order is preserved, count never exceeds 17 and never underflows.
- Reset mid-stream: count=5 with rd_pend=1, assert rst_n low -> next cycle m_valid=0, count=0. A new push of 0x3C emerges first, 3 cycles later.
